// File: rtl/step_clk_gen.sv
// step_clk_gen: CPU clock source for the FPGA display top.
// It has two modes. In single-step mode each debounced button press gives one
// fixed-width cpu_clk pulse. In free-run mode it generates a slow divided clock.
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   btn_clk    raw step button (async, bouncy, active-high)
//   run_mode   raw mode switch (async); 1 = free-run, 0 = single-step
//   cpu_clk    registered glitch-free clock to the CPU
//   busy       high whenever the pulse FSM is not idle
//   btn_level  debounced button level
//   step_count cpu_clk rising edges since reset, wraps modulo 2^32
module step_clk_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned HIGH_CYCLES     = 4,
  parameter int unsigned LOW_CYCLES      = 4,
  parameter int unsigned RUN_HALF        = 500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_clk,
  input  logic        run_mode,
  output logic        cpu_clk,
  output logic        busy,
  output logic        btn_level,
  output logic [31:0] step_count
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned STEP_W = 32;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_HALF - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP_HI = 3'd1,
    STEP_LO = 3'd2,
    RUN_HI  = 3'd3,
    RUN_LO  = 3'd4
  } state_e;

  // Two-flop synchronisers for the asynchronous inputs
  logic btn_meta_q, btn_s_q;
  logic run_meta_q, run_s_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn_clk;
      btn_s_q    <= btn_meta_q;
      run_meta_q <= run_mode;
      run_s_q    <= run_meta_q;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles to be accepted
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             btn_level_q, btn_level_d;
  logic             btn_prev_q;
  logic             press;

  always_comb begin
    deb_cnt_d   = '0;
    btn_level_d = btn_level_q;
    if (btn_s_q != btn_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_level_d = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      deb_cnt_q   <= '0;
      btn_level_q <= 1'b0;
      btn_prev_q  <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      btn_level_q <= btn_level_d;
      btn_prev_q  <= btn_level_q;
    end
  end

  // Rising edge of the debounced level only; releases are ignored
  assign press = btn_level_q & ~btn_prev_q;

  // Pulse FSM with a single phase counter cleared on every state entry
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic                cpu_clk_q, cpu_clk_d;
  logic                busy_q, busy_d;
  logic [STEP_W-1:0]   step_count_q, step_count_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        // Run mode wins over a coincident press
        if (run_s_q) begin
          state_d = RUN_HI;
        end else if (press) begin
          state_d = STEP_HI;
        end
      end
      STEP_HI: begin
        if (phase_q == HIGH_LAST) begin
          state_d = STEP_LO;
          phase_d = '0;
        end
      end
      STEP_LO: begin
        if (phase_q == LOW_LAST) begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      RUN_HI: begin
        if (phase_q == RUN_LAST) begin
          state_d = RUN_LO;
          phase_d = '0;
        end
      end
      RUN_LO: begin
        if (phase_q == RUN_LAST) begin
          state_d = run_s_q ? RUN_HI : IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    cpu_clk_d = (state_d == STEP_HI) || (state_d == RUN_HI);
    busy_d    = (state_d != IDLE);
    // Every high state is entered from a low one, so 0->1 marks a rising edge
    step_count_d = step_count_q;
    if (cpu_clk_d && !cpu_clk_q) begin
      step_count_d = step_count_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      cpu_clk_q    <= 1'b0;
      busy_q       <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cpu_clk_q    <= cpu_clk_d;
      busy_q       <= busy_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_clk    = cpu_clk_q;
  assign busy       = busy_q;
  assign btn_level  = btn_level_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_clk_gen.sv
// Self-checking bench for step_clk_gen: a behavioural model in terms of
// "cycles left in the current phase" is checked every cycle. Directed
// scenarios with literal expectations are followed by random stimulus.
module tb_step_clk_gen;

  localparam int unsigned DEB  = 8;
  localparam int unsigned HIGH = 3;
  localparam int unsigned LOW  = 3;
  localparam int unsigned HALF = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_clk = 1'b0;
  logic        run_mode = 1'b0;
  logic        cpu_clk;
  logic        busy;
  logic        btn_level;
  logic [31:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;
  int pre_req = 0;
  int pre_seen = 0;

  step_clk_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .HIGH_CYCLES(HIGH),
    .LOW_CYCLES(LOW),
    .RUN_HALF(HALF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .btn_clk(btn_clk),
    .run_mode(run_mode),
    .cpu_clk(cpu_clk),
    .busy(busy),
    .btn_level(btn_level),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic        m_b1 = 0, m_b2 = 0, m_r1 = 0, m_r2 = 0;
  logic        m_lvl = 0, m_lvl_prev = 0;
  int          m_disagree = 0;
  logic        m_hi = 0, m_is_run = 0;
  int          m_left = 0;
  logic [31:0] m_count = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_b1 = 0; m_b2 = 0; m_r1 = 0; m_r2 = 0;
      m_lvl = 0; m_lvl_prev = 0; m_disagree = 0;
      m_hi = 0; m_is_run = 0; m_left = 0; m_count = 0;
    end else begin
      if (m_left == 0) begin
        if (m_r2) begin
          m_hi = 1; m_is_run = 1; m_left = HALF; m_count = m_count + 1;
        end else if (m_lvl && !m_lvl_prev) begin
          m_hi = 1; m_is_run = 0; m_left = HIGH; m_count = m_count + 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_hi) begin
            m_hi = 0;
            m_left = m_is_run ? HALF : LOW;
          end else if (m_is_run && m_r2) begin
            m_hi = 1; m_left = HALF; m_count = m_count + 1;
          end
        end
      end
      m_lvl_prev = m_lvl;
      if (m_b2 == m_lvl) m_disagree = 0;
      else if (m_disagree == DEB - 1) begin
        m_lvl = m_b2; m_disagree = 0;
      end else m_disagree = m_disagree + 1;
      m_b2 = m_b1; m_b1 = btn_clk;
      m_r2 = m_r1; m_r1 = run_mode;
      if (pre_req != pre_seen) begin
        m_count = 32'hFFFF_FFFF;
        pre_seen = pre_req;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("model_cpu_clk", {31'd0, cpu_clk}, {31'd0, m_hi});
      check("model_busy", {31'd0, busy}, {31'd0, m_left != 0});
      check("model_btn_level", {31'd0, btn_level}, {31'd0, m_lvl});
      if (pre_req == pre_seen) check("model_step_count", step_count, m_count);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    resetn = 0; btn_clk = 0; run_mode = 0;
    idle(2);
    resetn = 1;
    tick();
  endtask

  // Waits up to limit cycles for cpu_clk to read high
  task automatic wait_cpu_high(input string name, input int limit);
    int k = 0;
    while (cpu_clk !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    if (cpu_clk !== 1'b1) check(name, {31'd0, cpu_clk}, 32'd1);
  endtask

  task automatic count_highs(input int n, output int hi, output int bz);
    hi = 0; bz = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_clk === 1'b1) hi++;
      if (busy === 1'b1) bz++;
    end
  endtask

  initial begin
    int lat, hi, bz;
    logic [15:0] pat;

    fork
      begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
      end
    join_none

    do_reset();
    fork compare_loop(); join_none
    check("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_btn_level", {31'd0, btn_level}, 32'd0);
    check("rst_step_count", step_count, 32'd0);

    // Clean press: debounce latency, pulse width, busy length
    btn_clk = 1;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (btn_level === 1'b1) lat = i;
    end
    check("debounce_latency", lat, 32'd10);
    count_highs(12, hi, bz);
    check("step_high_cycles", hi, 32'd3);
    check("step_busy_cycles", bz, 32'd6);
    check("step_count_one", step_count, 32'd1);
    btn_clk = 0;
    idle(20);
    check("step_count_after_release", step_count, 32'd1);

    // Bouncy press then bouncy release
    do_reset();
    for (int b = 0; b < 5; b++) begin
      btn_clk = (b % 2 == 0);
      idle(3);
    end
    btn_clk = 1;
    idle(20);
    for (int b = 0; b < 5; b++) begin
      btn_clk = (b % 2 == 1);
      idle(3);
    end
    btn_clk = 0;
    idle(30);
    check("bounce_one_pulse", step_count, 32'd1);

    // Held button gives one pulse; a later press gives another
    do_reset();
    btn_clk = 1;
    idle(40);
    check("hold_one_pulse", step_count, 32'd1);
    btn_clk = 0;
    idle(20);
    btn_clk = 1;
    idle(14);
    btn_clk = 0;
    idle(20);
    check("second_press", step_count, 32'd2);

    // Free-run: 4 high / 4 low, then stop mid high phase
    do_reset();
    run_mode = 1;
    wait_cpu_high("run_start_timeout", 20);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[14:0], cpu_clk};
      if (i < 15) tick();
    end
    check("run_pattern", {16'd0, pat}, 32'h0000_F0F0);
    check("run_count_two", step_count, 32'd2);
    tick();
    check("run_third_rise", {31'd0, cpu_clk}, 32'd1);
    run_mode = 0;
    count_highs(30, hi, bz);
    check("run_stop_high_tail", hi, 32'd3);
    check("run_stop_busy_tail", bz, 32'd7);
    check("run_stop_count", step_count, 32'd3);

    // Reset in the middle of a step pulse
    do_reset();
    btn_clk = 1;
    wait_cpu_high("step_start_timeout", 30);
    btn_clk = 0;
    resetn = 0;
    tick();
    check("midrst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("midrst_step_count", step_count, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    resetn = 1;
    count_highs(30, hi, bz);
    check("midrst_no_resume", hi, 32'd0);

    // Wrap of step_count
    do_reset();
    force dut.step_count_q = 32'hFFFF_FFFF;
    pre_req++;
    tick();
    release dut.step_count_q;
    check("preload_value", step_count, 32'hFFFF_FFFF);
    btn_clk = 1;
    idle(14);
    btn_clk = 0;
    idle(20);
    check("wrap_to_zero", step_count, 32'd0);

    // Random stimulus against the model
    do_reset();
    for (int it = 0; it < 200; it++) begin
      btn_clk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 60) == 0) begin
        resetn = 0;
        tick();
        resetn = 1;
      end
      idle($urandom_range(1, 20));
    end
    btn_clk = 0;
    run_mode = 0;
    idle(30);
    check("random_settles_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
